// File: rtl/elbeth_pkg.sv
// Shared definitions for the ELBETH data-memory path: access size encodings,
// the access FSM state type and the byte-lane helpers used by the store side.
package elbeth_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } dmem_state_t;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lo;
      SIZE_HALF: be = 4'b0011 << {lo[1], 1'b0};
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Sub-word store data is copied to every lane so the byte enables alone pick the target.
  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] r;
    r = w;
    case (size)
      SIZE_BYTE: r = {4{w[7:0]}};
      SIZE_HALF: r = {2{w[15:0]}};
      default:   r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elbeth_load_extend.sv
// Combinational load lane select with sign/zero extension; shared with the
// writeback mux, so it carries no state of its own.
module elbeth_load_extend
  import elbeth_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    data = '0;
    case (size)
      SIZE_BYTE: data = {{24{sign & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{16{sign & half_sel[15]}}, half_sel};
      SIZE_WORD: data = word;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/elbeth_dmem_interface.sv
// ELBETH data-memory access unit: one registered load/store, aligned bus access,
// ready/error handshake with watchdog. Define ELBETH_MISALIGN_TRAP_EN to trap misaligned accesses.
module elbeth_dmem_interface
  import elbeth_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exs_mem_en,
  input  logic        exs_mem_wr,
  input  logic [31:0] exs_addr,
  input  logic [31:0] exs_w_data,
  input  logic [1:0]  exs_data_size,
  input  logic        exs_data_sign,
  output logic        exs_mem_ready,
  output logic        exs_mem_error,
  output logic [31:0] exs_r_data,
  output logic [31:0] dmem_addr,
  output logic        dmem_en,
  output logic [3:0]  dmem_wr,
  output logic [31:0] dmem_w_data,
  input  logic [31:0] dmem_r_data,
  input  logic        dmem_ready,
  input  logic        dmem_error
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  dmem_state_t state_q, state_d;
  logic [1:0]      lane_q;
  logic [1:0]      size_q;
  logic            sign_q;
  logic            resp_err_q;
  logic [31:0]     rdata_q;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            req_legal;
  logic [31:0]     load_data;

  elbeth_load_extend u_load_extend (
    .word (dmem_r_data),
    .lane (lane_q),
    .size (size_q),
    .sign (sign_q),
    .data (load_data)
  );

  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    req_legal = (exs_data_size != SIZE_ILLEGAL);
`ifdef ELBETH_MISALIGN_TRAP_EN
    if (exs_data_size == SIZE_HALF && exs_addr[0])
      req_legal = 1'b0;
    if (exs_data_size == SIZE_WORD && exs_addr[1:0] != 2'b00)
      req_legal = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Error beats ready, ready beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (exs_mem_en) state_d = req_legal ? ACCESS : RESP;
      ACCESS:  if (dmem_error || dmem_ready || wd_expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= 2'b00;
      size_q      <= SIZE_BYTE;
      sign_q      <= 1'b0;
      resp_err_q  <= 1'b0;
      rdata_q     <= '0;
      wd_cnt      <= '0;
      dmem_en     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wr     <= 4'b0000;
      dmem_w_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exs_mem_en) begin
            lane_q     <= exs_addr[1:0];
            size_q     <= exs_data_size;
            sign_q     <= exs_data_sign;
            resp_err_q <= !req_legal;
            rdata_q    <= '0;
            wd_cnt     <= '0;
            if (req_legal) begin
              dmem_en     <= 1'b1;
              dmem_addr   <= {exs_addr[31:2], 2'b00};
              dmem_wr     <= exs_mem_wr ? byte_enables(exs_data_size, exs_addr[1:0]) : 4'b0000;
              dmem_w_data <= replicate_store(exs_data_size, exs_w_data);
            end
          end
        end
        ACCESS: begin
          // Leaving without a clean ready means bus error or watchdog expiry.
          if (state_d != ACCESS) begin
            dmem_en    <= 1'b0;
            dmem_wr    <= 4'b0000;
            resp_err_q <= dmem_error || !dmem_ready;
            rdata_q    <= (dmem_error || !dmem_ready) ? 32'h0 : load_data;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign exs_mem_ready = (state_q == RESP);
  assign exs_mem_error = exs_mem_ready & resp_err_q;
  assign exs_r_data    = exs_mem_ready ? rdata_q : 32'h0;

endmodule
